// File: rtl/wb_stage.sv
// wb_stage: writeback stage that formats load data, drives the register-file write port
// for one cycle per retired instruction, and counts retirements.
module wb_stage #(
    parameter int LOAD_TIMEOUT = 16,
    parameter int CNT_W        = 32
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic             i_regWrite,
    input  logic [4:0]       i_rd,
    input  logic [1:0]       i_resSel,
    input  logic [31:0]      i_aluRes,
    input  logic [31:0]      i_pcPlus4,
    input  logic [2:0]       i_funct3,
    input  logic             i_memRvalid,
    input  logic [31:0]      i_memRdata,
    output logic             o_wrSig,
    output logic [4:0]       o_wrReg,
    output logic [31:0]      o_wrData,
    output logic             en_WB,
    output logic             o_loadErr,
    output logic [CNT_W-1:0] o_retireCnt
);
    localparam int TW = $clog2(LOAD_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, LOAD_WAIT, COMMIT} state_t;

    state_t      state;
    logic [TW-1:0] timer;
    logic [4:0]  rd;
    logic        reg_write;
    logic [1:0]  res_sel;
    logic [2:0]  funct3;
    logic [31:0] alu_res;
    logic [31:0] pc_plus4;
    logic        accept;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] load_data;

    assign o_ready = state != LOAD_WAIT;
    assign accept  = i_valid && o_ready;

    // Lane selection uses the captured load address, not the live one.
    always_comb begin
        byte_v    = i_memRdata[{alu_res[1:0], 3'b000} +: 8];
        half_v    = i_memRdata[{alu_res[1], 4'b0000} +: 16];
        load_data = funct3 == 3'b000 ? {{24{byte_v[7]}}, byte_v} :
                    funct3 == 3'b001 ? {{16{half_v[15]}}, half_v} :
                    funct3 == 3'b100 ? {24'b0, byte_v} :
                    funct3 == 3'b101 ? {16'b0, half_v} : i_memRdata;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state       <= IDLE;
            timer       <= '0;
            rd          <= '0;
            reg_write   <= 1'b0;
            res_sel     <= '0;
            funct3      <= '0;
            alu_res     <= '0;
            pc_plus4    <= '0;
            o_wrSig     <= 1'b0;
            o_wrReg     <= '0;
            o_wrData    <= '0;
            en_WB       <= 1'b0;
            o_loadErr   <= 1'b0;
            o_retireCnt <= '0;
        end else begin
            en_WB     <= 1'b0;
            o_wrSig   <= 1'b0;
            o_loadErr <= 1'b0;
            if (state == LOAD_WAIT) begin
                if (i_memRvalid) begin
                    state       <= COMMIT;
                    en_WB       <= 1'b1;
                    o_wrSig     <= reg_write && rd != 5'd0;
                    o_wrReg     <= rd;
                    o_wrData    <= load_data;
                    o_retireCnt <= o_retireCnt + CNT_W'(1);
                end else if (timer == TW'(LOAD_TIMEOUT - 1)) begin
                    state       <= COMMIT;
                    en_WB       <= 1'b1;
                    o_loadErr   <= 1'b1;
                    o_wrReg     <= rd;
                    o_wrData    <= '0;
                    o_retireCnt <= o_retireCnt + CNT_W'(1);
                end else begin
                    timer <= timer + TW'(1);
                end
            end else if (accept) begin
                rd        <= i_rd;
                reg_write <= i_regWrite;
                res_sel   <= i_resSel;
                funct3    <= i_funct3;
                alu_res   <= i_aluRes;
                pc_plus4  <= i_pcPlus4;
                if (i_resSel == 2'b01) begin
                    state <= LOAD_WAIT;
                    timer <= '0;
                end else begin
                    state       <= COMMIT;
                    en_WB       <= 1'b1;
                    o_wrSig     <= i_regWrite && i_rd != 5'd0;
                    o_wrReg     <= i_rd;
                    o_wrData    <= i_resSel == 2'b10 ? i_pcPlus4 : i_aluRes;
                    o_retireCnt <= o_retireCnt + CNT_W'(1);
                end
            end else begin
                state <= IDLE;
            end
        end
    end
endmodule
